scsi_inq_reader: RTL and testbench

SCSI_INQ_READER -- requirements
Module: scsi_inq_reader

---
 rtl/scsi_inq_reader.sv | 128 ++++++++++++
 tb/tb_scsi_inq_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_inq_reader.sv
// Purpose: frames REC_WORDS-word inquiry records out of a show-ahead FIFO, counting non-zero words per record.
// Latency: one cycle from FIFO pop to oVALID; records run back-to-back at one word per cycle.
// Backpressure: iREADY low holds the output word and stops pops. Stats counters exist only with SCSI_INQ_READER_STATS_EN.
module scsi_inq_reader #(
    parameter int REC_WORDS = 8    // legal range 2..16
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iFLUSH,
    input  logic [127:0] iFIFO_Q,
    input  logic         iFIFO_EMPTY,
    input  logic [7:0]   iFIFO_USEDW,
    output logic         oFIFO_RD,
    output logic         oFIFO_SCLR,
    output logic [127:0] oDATA,
    output logic         oVALID,
    input  logic         iREADY,
    output logic         oSOP,
    output logic         oEOP,
    output logic [4:0]   oNZ_WORDS,
    output logic         oBUSY,
    output logic [31:0]  oREC_CNT,
    output logic [31:0]  oZERO_REC_CNT
);

    typedef enum logic {
        IDLE,
        XFR
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(REC_WORDS - 1);
    localparam logic [8:0] REC_LEN  = 9'(REC_WORDS);

    state_t     state;
    logic [3:0] word_idx;
    logic [4:0] nz_acc;

    logic [8:0] used_ext;
    logic       can_start;
    logic       more_after_last;
    logic       pop;
    logic       is_last;
    logic [4:0] nz_next;

    assign used_ext        = {1'b0, iFIFO_USEDW};
    // Only whole records are started, so a partially written record never reaches the consumer.
    assign can_start       = used_ext >= REC_LEN;
    // Popping the last word of a record: the words left behind already form another full record.
    assign more_after_last = used_ext > REC_LEN;
    assign is_last         = word_idx == LAST_IDX;
    assign nz_next         = nz_acc + {4'd0, |iFIFO_Q};

    // Pop whenever the output register is free or being drained this cycle; flush and reset win.
    assign pop      = (state == XFR) & ~iFIFO_EMPTY & (~oVALID | iREADY) & ~iFLUSH & ~iRST;
    assign oFIFO_RD = pop;
    assign oBUSY    = (state == XFR) | oVALID;

    // Record framing state machine, output word register and non-zero accumulator.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            word_idx   <= 4'd0;
            nz_acc     <= 5'd0;
            oDATA      <= '0;
            oVALID     <= 1'b0;
            oSOP       <= 1'b0;
            oEOP       <= 1'b0;
            oNZ_WORDS  <= 5'd0;
            oFIFO_SCLR <= 1'b0;
        end else begin
            oFIFO_SCLR <= iFLUSH;
            if (iFLUSH) begin
                // Undelivered words are dropped; the FIFO is cleared on the following edge.
                state    <= IDLE;
                oVALID   <= 1'b0;
                word_idx <= 4'd0;
                nz_acc   <= 5'd0;
            end else begin
                if (pop) begin
                    oDATA     <= iFIFO_Q;
                    oVALID    <= 1'b1;
                    oSOP      <= word_idx == 4'd0;
                    oEOP      <= is_last;
                    oNZ_WORDS <= nz_next;
                    if (is_last) begin
                        word_idx <= 4'd0;
                        nz_acc   <= 5'd0;
                        // Chain straight into the next record so the boundary has no bubble.
                        state    <= more_after_last ? XFR : IDLE;
                    end else begin
                        word_idx <= word_idx + 4'd1;
                        nz_acc   <= nz_next;
                    end
                end else if (oVALID && iREADY) begin
                    oVALID <= 1'b0;
                end
                if (state == IDLE && can_start) begin
                    state <= XFR;
                end
            end
        end
    end

`ifdef SCSI_INQ_READER_STATS_EN
    logic [31:0] rec_cnt;
    logic [31:0] zero_rec_cnt;

    // Delivered-record statistics; they survive a flush and wrap naturally.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rec_cnt      <= 32'd0;
            zero_rec_cnt <= 32'd0;
        end else if (oVALID && iREADY && oEOP) begin
            rec_cnt <= rec_cnt + 32'd1;
            if (oNZ_WORDS == 5'd0) begin
                zero_rec_cnt <= zero_rec_cnt + 32'd1;
            end
        end
    end

    assign oREC_CNT      = rec_cnt;
    assign oZERO_REC_CNT = zero_rec_cnt;
`else
    assign oREC_CNT      = 32'd0;
    assign oZERO_REC_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_scsi_inq_reader.sv
// Bench for scsi_inq_reader: a queue stands in for the misc FIFO and a record-level model predicts every output.
// Inputs change on the falling edge; outputs are compared 1 ns later, well away from the rising edge.
module tb_scsi_inq_reader;

    localparam int RW = 8;

    logic         iCLK = 1'b0;
    logic         iRST = 1'b1;
    logic         iFLUSH = 1'b0;
    logic [127:0] iFIFO_Q = '0;
    logic         iFIFO_EMPTY = 1'b1;
    logic [7:0]   iFIFO_USEDW = 8'd0;
    logic         oFIFO_RD;
    logic         oFIFO_SCLR;
    logic [127:0] oDATA;
    logic         oVALID;
    logic         iREADY = 1'b1;
    logic         oSOP;
    logic         oEOP;
    logic [4:0]   oNZ_WORDS;
    logic         oBUSY;
    logic [31:0]  oREC_CNT;
    logic [31:0]  oZERO_REC_CNT;

    scsi_inq_reader #(.REC_WORDS(RW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFLUSH(iFLUSH),
        .iFIFO_Q(iFIFO_Q), .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_USEDW(iFIFO_USEDW),
        .oFIFO_RD(oFIFO_RD), .oFIFO_SCLR(oFIFO_SCLR),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
        .oSOP(oSOP), .oEOP(oEOP), .oNZ_WORDS(oNZ_WORDS), .oBUSY(oBUSY),
        .oREC_CNT(oREC_CNT), .oZERO_REC_CNT(oZERO_REC_CNT)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    // FIFO contents
    logic [127:0] fq[$];

    // Record-level reference model
    bit           m_active;
    int           m_idx;
    int           m_nzacc;
    bit           m_valid;
    logic [127:0] m_data;
    bit           m_sop, m_eop;
    int           m_nz;
    int           m_out_idx;
    bit           m_sclr;
    int unsigned  m_rec, m_zero;

    // Stimulus controls and observations
    bit drv_rst = 1'b1, drv_flush = 1'b0, drv_ready = 1'b1;
    int rd_seen, acc_seen, sclr_seen, cur_run, max_run, obs_eop_nz;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd_word(input int zero_pct);
        logic [127:0] w;
        if ($urandom_range(0, 99) < zero_pct) w = '0;
        else w = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
        return w;
    endfunction

    function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef SCSI_INQ_READER_STATS_EN
        return 32'(v);
`else
        return 32'd0 + 0 * v;
`endif
    endfunction

    task automatic clear_obs();
        rd_seen = 0; acc_seen = 0; sclr_seen = 0; cur_run = 0; max_run = 0; obs_eop_nz = -1;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step();
        bit pop, acc, old_sclr;
        int size_now;
        logic [127:0] head;
        @(negedge iCLK);
        iRST        = drv_rst;
        iFLUSH      = drv_flush;
        iREADY      = drv_ready;
        size_now    = fq.size();
        iFIFO_EMPTY = (size_now == 0);
        iFIFO_Q     = (size_now == 0) ? 128'd0 : fq[0];
        iFIFO_USEDW = 8'(size_now);
        #1;
        if (drv_rst) begin
            check("rd_in_reset", oFIFO_RD, 1'b0);
            m_active = 0; m_idx = 0; m_nzacc = 0; m_valid = 0; m_data = '0;
            m_sop = 0; m_eop = 0; m_nz = 0; m_sclr = 0; m_rec = 0; m_zero = 0;
            return;
        end
        pop = m_active && size_now > 0 && (!m_valid || drv_ready) && !drv_flush;
        acc = m_valid && drv_ready;
        check("fifo_rd", oFIFO_RD, pop);
        check("valid", oVALID, m_valid);
        check("busy", oBUSY, m_active || m_valid);
        check("sclr", oFIFO_SCLR, m_sclr);
        check("rec_cnt", oREC_CNT, exp_stat(m_rec));
        check("zero_cnt", oZERO_REC_CNT, exp_stat(m_zero));
        if (m_valid) begin
            check("data", oDATA, m_data);
            check("sop", oSOP, m_sop);
            check("eop", oEOP, m_eop);
            check("nz", oNZ_WORDS, 128'(m_nz));
        end
        // observations for the directed checks
        rd_seen   += int'(oFIFO_RD);
        sclr_seen += int'(oFIFO_SCLR);
        if (oVALID && iREADY) begin
            acc_seen++;
            if (oEOP) obs_eop_nz = int'(oNZ_WORDS);
        end
        cur_run = oVALID ? cur_run + 1 : 0;
        if (cur_run > max_run) max_run = cur_run;
        // model advance
        old_sclr = m_sclr;
        if (acc && m_eop) begin
            m_rec++;
            if (m_nz == 0) m_zero++;
        end
        m_sclr = drv_flush;
        if (drv_flush) begin
            m_active = 0; m_valid = 0; m_idx = 0; m_nzacc = 0;
        end else begin
            if (pop) begin
                head      = fq.pop_front();
                m_data    = head;
                m_valid   = 1;
                m_sop     = (m_idx == 0);
                m_eop     = (m_idx == RW - 1);
                m_nzacc  += (head != 0) ? 1 : 0;
                m_nz      = m_nzacc;
                m_out_idx = m_idx;
                if (m_idx == RW - 1) begin
                    m_idx = 0;
                    m_nzacc = 0;
                    m_active = (size_now - 1) >= RW;
                end else begin
                    m_idx++;
                end
            end else if (acc) begin
                m_valid = 0;
            end
            if (!m_active && !pop && size_now >= RW) m_active = 1;
        end
        if (old_sclr) fq.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit hold_done;
        int hold_left;

        // Reset and reset-state checks
        drv_rst = 1; run(3);
        drv_rst = 0;
        @(posedge iCLK); #1;
        check("rst_valid", oVALID, 1'b0);
        check("rst_data", oDATA, 128'd0);
        check("rst_sop", oSOP, 1'b0);
        check("rst_eop", oEOP, 1'b0);
        check("rst_nz", oNZ_WORDS, 5'd0);
        check("rst_sclr", oFIFO_SCLR, 1'b0);
        check("rst_rec", oREC_CNT, 32'd0);
        check("rst_zero", oZERO_REC_CNT, 32'd0);

        // 7 words never start a record; the 8th does: 3 non-zero + 5 zero words
        clear_obs();
        for (int i = 0; i < 3; i++) fq.push_back(rnd_word(0));
        for (int i = 0; i < 4; i++) fq.push_back(128'd0);
        run(6);
        check("partial_no_rd", rd_seen, 0);
        fq.push_back(128'd0);
        run(14);
        check("rec1_pops", rd_seen, RW);
        check("rec1_nz", obs_eop_nz, 3);
        check("rec1_cnt", oREC_CNT, exp_stat(1));

        // Consumer stalls 4 cycles on word 2
        clear_obs();
        for (int i = 0; i < RW; i++) fq.push_back(rnd_word(0));
        hold_done = 0; hold_left = 0;
        for (int i = 0; i < 24; i++) begin
            if (!hold_done && m_valid && m_out_idx == 2) begin
                hold_done = 1; hold_left = 4;
            end
            drv_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            step();
        end
        drv_ready = 1;
        check("stall_pops", rd_seen, RW);
        check("stall_accepts", acc_seen, RW);

        // Two records back to back
        clear_obs();
        for (int i = 0; i < 2 * RW; i++) fq.push_back(rnd_word(30));
        run(26);
        check("b2b_valid_run", max_run, 2 * RW);
        check("b2b_accepts", acc_seen, 2 * RW);

        // Flush at word 4
        clear_obs();
        for (int i = 0; i < RW; i++) fq.push_back(rnd_word(0));
        for (int i = 0; i < 20; i++) begin
            drv_flush = (sclr_seen == 0) && !m_sclr && m_valid && m_out_idx == 4;
            step();
        end
        drv_flush = 0;
        check("flush_sclr_pulses", sclr_seen, 1);
        check("flush_accepts", acc_seen, 5);

        // All-zero record
        clear_obs();
        for (int i = 0; i < RW; i++) fq.push_back(128'd0);
        run(14);
        check("zero_rec_nz", obs_eop_nz, 0);

        // Reset in the middle of a record, then flush away the leftovers
        for (int i = 0; i < RW; i++) fq.push_back(rnd_word(20));
        run(4);
        drv_rst = 1; run(2);
        drv_rst = 0;
        drv_flush = 1; run(1);
        drv_flush = 0; run(4);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (fq.size() < 40 && $urandom_range(0, 99) < 45) fq.push_back(rnd_word(25));
            drv_ready = ($urandom_range(0, 99) < 70);
            drv_flush = ($urandom_range(0, 249) == 0);
            step();
        end
        drv_flush = 0; drv_ready = 1;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
